// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the two-port RAM arbiter: bus widths, FSM state encoding, port IDs.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of both requester ports and the RAM strobe interface.
// Latency: n/a (wiring only).
// Backpressure: requesters hold *_req until their *_ack pulse.
// slave modport = arbiter view, master modport = clients + RAM view.
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_read, mem_write, mem_raddr, mem_waddr, mem_wdata,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_read, mem_write, mem_raddr, mem_waddr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// 2-way round-robin grant with last-grant memory; grant is combinational from req.
// Latency: 0 cycles to grant; last_grant updates on the granting edge.
// Backpressure: no grant while gnt_en_i is low (owner FSM busy).
// Ports: clk/rst_n, gnt_en_i, req_a_i/req_b_i in; gnt_vld_o/gnt_port_o out.
module rr_arbiter2
  import ram_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic gnt_en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_vld_o,
  output logic gnt_port_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_vld_o = gnt_en_i & (req_a_i | req_b_i);
    // On a tie, the port that did not win last time gets the slot.
    if (req_a_i && req_b_i) begin
      gnt_port_o = ~last_grant_q;
    end else if (req_b_i) begin
      gnt_port_o = PORT_B;
    end else begin
      gnt_port_o = PORT_A;
    end
    last_grant_d = gnt_vld_o ? gnt_port_o : last_grant_q;
  end

  // Reset to B so the first tie after reset goes to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 16x8 registered-read RAM between ports A and B, one access at a time.
// Latency: strobe 1 cycle after grant; ack 2 cycles (write) / 3 cycles (read) after grant.
// Backpressure: losing requester holds req high in IDLE until granted; no queueing.
// Ports: clock, reset (async active-low), bus (slave modport: A/B request ports, RAM strobes, busy).
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  ram_port_arbiter_if.slave    bus
);

  state_e            state_q;
  logic              port_q;
  logic              we_q;
  logic              busy_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_raddr_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  logic              gnt_vld;
  logic              gnt_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .clk        (clock),
    .rst_n      (reset),
    .gnt_en_i   (state_q == ST_IDLE),
    .req_a_i    (bus.a_req),
    .req_b_i    (bus.b_req),
    .gnt_vld_o  (gnt_vld),
    .gnt_port_o (gnt_port)
  );

  // Command fields of whichever port wins this cycle.
  assign sel_we    = (gnt_port == PORT_B) ? bus.b_we    : bus.a_we;
  assign sel_addr  = (gnt_port == PORT_B) ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = (gnt_port == PORT_B) ? bus.b_wdata : bus.a_wdata;

  // The RAM-side address/data registers double as the command latch: they
  // load only on grant, so requester changes after grant are never seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_A;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            state_q     <= ST_ISSUE;
            port_q      <= gnt_port;
            we_q        <= sel_we;
            busy_q      <= 1'b1;
            mem_write_q <= sel_we;
            mem_read_q  <= ~sel_we;
            if (sel_we) begin
              mem_waddr_q <= sel_addr;
              mem_wdata_q <= sel_wdata;
            end else begin
              mem_raddr_q <= sel_addr;
            end
          end
        end
        ST_ISSUE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (we_q) begin
            state_q <= ST_ACK;
            a_ack_q <= (port_q == PORT_A);
            b_ack_q <= (port_q == PORT_B);
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // RAM output is valid this cycle (one cycle after the read strobe).
          if (port_q == PORT_A) begin
            a_rdata_q <= bus.mem_rdata;
          end else begin
            b_rdata_q <= bus.mem_rdata;
          end
          a_ack_q <= (port_q == PORT_A);
          b_ack_q <= (port_q == PORT_B);
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule
